// File: rtl/buzzer_sequencer_pkg.sv
// Shared definitions for the buzzer sequencer: tone one-hot codes, FSM
// state encoding, counter/queue widths and parameter defaults.
// Optional feature macro: BUZZER_SEQ_GAP_EN adds the GAP state.
package buzzer_sequencer_pkg;

  localparam int UNIT_MS_DEFAULT = 100;
  localparam int GAP_MS_DEFAULT  = 50;

  localparam int CNT_W  = 10;
  localparam int NOTA_W = 4;
  localparam int DUR_W  = 3;
  localparam int ITEM_W = NOTA_W + DUR_W;

  localparam logic [NOTA_W-1:0] NOTA_125HZ = 4'b0001;
  localparam logic [NOTA_W-1:0] NOTA_250HZ = 4'b0010;
  localparam logic [NOTA_W-1:0] NOTA_333HZ = 4'b0100;
  localparam logic [NOTA_W-1:0] NOTA_500HZ = 4'b1000;

`ifdef BUZZER_SEQ_GAP_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_t;
`endif

  function automatic logic nota_valida(input logic [NOTA_W-1:0] n);
    return n inside {NOTA_125HZ, NOTA_250HZ, NOTA_333HZ, NOTA_500HZ};
  endfunction

endpackage

// File: rtl/fila_notas.sv
// Note request FIFO: WIDTH-bit entries, DEPTH (power of two) deep.
// Ports:
//   clock, reset      rising-edge clock, async active-high reset
//   push, din         write din when not full
//   pop, dout         drop head when not empty; dout is the current head
//   flush             empty the queue (wins over push/pop)
//   full, empty       occupancy flags
//   count             occupancy, 0..DEPTH
module fila_notas #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/buzzer_sequencer.sv
// Buzzer note sequencer: queues {nota, duracao} requests and plays them in
// FIFO order by driving the buzzer conta/seletor inputs.
// Optional feature macro: BUZZER_SEQ_GAP_EN inserts GAP_MS silent cycles
// between consecutive notes (GAP state + LOAD cycle); GAP_MS must be >= 2.
// Ports:
//   clock, reset     1 kHz clock, async active-high reset
//   req              enqueue request for {nota, duracao}
//   nota             one-hot tone select
//   duracao          note length in UNIT_MS units, 1..7
//   cancelar         flush queue and abort the current note
//   pronto           queue not full
//   nivel            queue occupancy
//   tocando          sequencer busy (not IDLE)
//   buzzer_conta     buzzer enable
//   buzzer_seletor   buzzer one-hot tone select
//   fim_nota         one-cycle pulse per completed note
//   erro             one-cycle pulse per malformed request
//
// state | meaning
// IDLE  | nothing playing, waiting for a queued note
// LOAD  | pop head, load tone and length counter
// PLAY  | buzzer on for duracao*UNIT_MS cycles
// GAP   | silent pause between notes (gap build only)
module buzzer_sequencer
  import buzzer_sequencer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int UNIT_MS = UNIT_MS_DEFAULT,
  parameter int GAP_MS  = GAP_MS_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic [NOTA_W-1:0] nota,
  input  logic [DUR_W-1:0]  duracao,
  input  logic              cancelar,
  output logic              pronto,
  output logic [2:0]        nivel,
  output logic              tocando,
  output logic              buzzer_conta,
  output logic [NOTA_W-1:0] buzzer_seletor,
  output logic              fim_nota,
  output logic              erro
);

  localparam int CW = $clog2(DEPTH + 1);

`ifdef BUZZER_SEQ_GAP_EN
  localparam bit GAP_OK = (GAP_MS >= 2) && (GAP_MS - 1 < (1 << CNT_W));
`else
  localparam bit GAP_OK = (GAP_MS >= 0);
`endif

  localparam bit PARAMS_OK = (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0) &&
                             (DEPTH <= 7) && (UNIT_MS >= 1) &&
                             (7 * UNIT_MS < (1 << CNT_W)) && GAP_OK;

  if (!PARAMS_OK) begin : g_param_check
    $error("buzzer_sequencer: unsupported DEPTH/UNIT_MS/GAP_MS combination");
  end

  localparam logic [CNT_W-1:0] UNIT_C  = CNT_W'(UNIT_MS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic [NOTA_W-1:0]   nota_reg;
  logic [NOTA_W-1:0]   nota_next;
  logic                fim_next;
  logic                erro_next;
  logic                req_valida;
  logic                push;
  logic                pop;
  logic                fila_full;
  logic                fila_empty;
  logic [ITEM_W-1:0]   head;
  logic [CW-1:0]       fila_count;

  // A full queue silently drops any request, well-formed or not.
  assign req_valida = nota_valida(nota) && (duracao != '0);
  assign push       = req && !cancelar && !fila_full && req_valida;
  assign erro_next  = req && !cancelar && !fila_full && !req_valida;

  fila_notas #(
    .WIDTH (ITEM_W),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fila (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (cancelar),
    .din   ({nota, duracao}),
    .dout  (head),
    .full  (fila_full),
    .empty (fila_empty),
    .count (fila_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      nota_reg <= '0;
      fim_nota <= 1'b0;
      erro     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      nota_reg <= nota_next;
      fim_nota <= fim_next;
      erro     <= erro_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    nota_next  = nota_reg;
    pop        = 1'b0;
    fim_next   = 1'b0;
    if (cancelar) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      nota_next  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fila_empty) state_next = ST_LOAD;
        end
        ST_LOAD: begin
          pop        = 1'b1;
          nota_next  = head[ITEM_W-1:DUR_W];
          cnt_next   = CNT_W'(head[DUR_W-1:0]) * UNIT_C;
          state_next = ST_PLAY;
        end
        ST_PLAY: begin
          if (cnt <= CNT_ONE) begin
            fim_next = 1'b1;
`ifdef BUZZER_SEQ_GAP_EN
            // LOAD adds one more silent cycle, so GAP covers GAP_MS-1.
            state_next = ST_GAP;
            cnt_next   = CNT_W'(GAP_MS - 1);
`else
            state_next = fila_empty ? ST_IDLE : ST_LOAD;
            cnt_next   = '0;
`endif
          end else begin
            cnt_next = cnt - 1'b1;
          end
        end
`ifdef BUZZER_SEQ_GAP_EN
        ST_GAP: begin
          if (cnt <= CNT_ONE) begin
            state_next = fila_empty ? ST_IDLE : ST_LOAD;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt - 1'b1;
          end
        end
`endif
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign buzzer_conta   = (state == ST_PLAY);
  assign buzzer_seletor = buzzer_conta ? nota_reg : '0;
  assign tocando        = (state != ST_IDLE);
  assign pronto         = !fila_full;
  assign nivel          = 3'(fila_count);

endmodule

// File: tb/tb_buzzer_sequencer.sv
module tb_buzzer_sequencer;

  localparam int DEPTH   = 4;
  localparam int UNIT_MS = 100;
  localparam int GAP_MS  = 50;
`ifdef BUZZER_SEQ_GAP_EN
  localparam int GAP_EXTRA  = GAP_MS - 1;
  localparam int EXP_SILENT = GAP_MS;
`else
  localparam int GAP_EXTRA  = 0;
  localparam int EXP_SILENT = 1;
`endif

  logic       clock;
  logic       reset;
  logic       req;
  logic [3:0] nota;
  logic [2:0] duracao;
  logic       cancelar;
  logic       pronto;
  logic [2:0] nivel;
  logic       tocando;
  logic       buzzer_conta;
  logic [3:0] buzzer_seletor;
  logic       fim_nota;
  logic       erro;

  buzzer_sequencer #(
    .DEPTH   (DEPTH),
    .UNIT_MS (UNIT_MS),
    .GAP_MS  (GAP_MS)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req            (req),
    .nota           (nota),
    .duracao        (duracao),
    .cancelar       (cancelar),
    .pronto         (pronto),
    .nivel          (nivel),
    .tocando        (tocando),
    .buzzer_conta   (buzzer_conta),
    .buzzer_seletor (buzzer_seletor),
    .fim_nota       (fim_nota),
    .erro           (erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Timeline reference model: a note popped at edge P with length L sounds
  // after edges P..P+L-1, fim_nota follows edge P+L, and the player may look
  // at the queue again from edge P+L (+ gap) onwards; a pop follows one edge
  // after the player sees a non-empty queue.
  int         cyc = 0;
  logic [6:0] q[$];
  int         pop_at  = -1;
  int         p_start = -1;
  int         end_at  = -1;
  int         free_at = -1;
  logic [3:0] cur_nota = '0;
  bit         exp_fim  = 1'b0;
  bit         exp_erro = 1'b0;

  function automatic bit valid_req(input logic [3:0] n, input logic [2:0] d);
    return ($countones(n) == 1) && (d != 3'd0);
  endfunction

  task automatic model_clear();
    q.delete();
    pop_at   = -1;
    p_start  = -1;
    end_at   = -1;
    free_at  = -1;
    cur_nota = '0;
    exp_fim  = 1'b0;
    exp_erro = 1'b0;
  endtask

  task automatic model_edge();
    int pre;
    bit full;
    bit sched;
    logic [6:0] item;
    cyc++;
    if (reset || cancelar) begin
      model_clear();
      return;
    end
    pre     = q.size();
    full    = (pre == DEPTH);
    exp_fim = (cyc == end_at);
    sched   = (cyc >= free_at) && (pop_at < 0) && (pre > 0);
    if (pop_at == cyc) begin
      item     = q.pop_front();
      cur_nota = item[6:3];
      p_start  = cyc;
      end_at   = cyc + int'(item[2:0]) * UNIT_MS;
      free_at  = end_at + GAP_EXTRA;
      pop_at   = -1;
    end
    exp_erro = req && !full && !valid_req(nota, duracao);
    if (req && !full && valid_req(nota, duracao)) q.push_back({nota, duracao});
    if (sched) pop_at = cyc + 1;
  endtask

  task automatic compare_all();
    bit conta_e;
    conta_e = (p_start >= 0) && (cyc >= p_start) && (cyc < end_at);
    chk("pronto", int'(pronto), int'(q.size() < DEPTH));
    chk("nivel", int'(nivel), q.size());
    chk("tocando", int'(tocando), int'((pop_at >= 0) || (cyc < free_at)));
    chk("conta", int'(buzzer_conta), int'(conta_e));
    chk("seletor", int'(buzzer_seletor), conta_e ? int'(cur_nota) : 0);
    chk("fim_nota", int'(fim_nota), int'(exp_fim));
    chk("erro", int'(erro), int'(exp_erro));
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic r, input logic [3:0] n, input logic [2:0] d, input logic c);
    req      = r;
    nota     = n;
    duracao  = d;
    cancelar = c;
  endtask

  initial begin
    int first;
    int len;
    int fims;
    int seen;
    int silent;
    bit had;
    bit closed;
    bit prev;
    int ord[$];
    logic [3:0] exp_ord [4];

    reset = 1'b1;
    drive(0, 4'd0, 3'd0, 0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // single note: latency and length
    drive(1, 4'b0010, 3'd1, 0);
    tick();
    drive(0, 4'd0, 3'd0, 0);
    first = -1;
    len   = 0;
    fims  = 0;
    for (int i = 1; i <= 120; i++) begin
      tick();
      if (buzzer_conta) begin
        len++;
        if (first < 0) first = i;
      end
      if (fim_nota) fims++;
    end
    chk("latency", first, 2);
    chk("conta_len", len, UNIT_MS);
    chk("single_fim", fims, 1);
    chk("single_idle", int'(tocando), 0);

    // fill the queue behind a playing note, fifth request dropped
    drive(1, 4'b1000, 3'd1, 0);
    tick();
    drive(0, 4'd0, 3'd0, 0);
    repeat (5) tick();
    exp_ord[0] = 4'b0001;
    exp_ord[1] = 4'b0010;
    exp_ord[2] = 4'b0100;
    exp_ord[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      drive(1, exp_ord[i], 3'd1, 0);
      tick();
    end
    chk("full_pronto", int'(pronto), 0);
    chk("full_nivel", int'(nivel), 4);
    drive(1, 4'b0001, 3'd1, 0);
    tick();
    drive(0, 4'd0, 3'd0, 0);
    chk("drop_nivel", int'(nivel), 4);
    chk("drop_erro", int'(erro), 0);
    prev = 1'b1;
    fims = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (buzzer_conta && !prev) ord.push_back(int'(buzzer_seletor));
      prev = buzzer_conta;
      if (fim_nota) fims++;
    end
    chk("order_cnt", ord.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < ord.size()) chk("order", ord[i], int'(exp_ord[i]));
    chk("fifo_fims", fims, 5);

    // malformed requests
    drive(1, 4'b0011, 3'd1, 0);
    tick();
    chk("erro_nota", int'(erro), 1);
    drive(1, 4'b0010, 3'd0, 0);
    tick();
    chk("erro_dur", int'(erro), 1);
    chk("erro_nivel", int'(nivel), 0);
    drive(0, 4'd0, 3'd0, 0);
    tick();
    chk("erro_clear", int'(erro), 0);

    // cancel 30 cycles into a 3-unit note with two more queued
    drive(1, 4'b0100, 3'd3, 0);
    tick();
    drive(1, 4'b0001, 3'd1, 0);
    tick();
    drive(1, 4'b1000, 3'd1, 0);
    tick();
    drive(0, 4'd0, 3'd0, 0);
    seen = 0;
    for (int i = 0; i < 100 && seen < 30; i++) begin
      if (buzzer_conta) seen++;
      if (seen < 30) tick();
    end
    chk("cancel_setup", seen, 30);
    drive(0, 4'd0, 3'd0, 1);
    tick();
    drive(0, 4'd0, 3'd0, 0);
    chk("cancel_conta", int'(buzzer_conta), 0);
    chk("cancel_seletor", int'(buzzer_seletor), 0);
    chk("cancel_nivel", int'(nivel), 0);
    fims = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (fim_nota) fims++;
    end
    chk("cancel_fim", fims, 0);

    // silence between two back-to-back notes
    drive(1, 4'b0010, 3'd1, 0);
    tick();
    drive(1, 4'b0100, 3'd1, 0);
    tick();
    drive(0, 4'd0, 3'd0, 0);
    silent = 0;
    had    = 1'b0;
    closed = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (buzzer_conta) begin
        if (silent > 0) closed = 1'b1;
        had = 1'b1;
      end else if (had && !closed) begin
        silent++;
      end
    end
    chk("gap_len", silent, EXP_SILENT);

    // asynchronous reset in the middle of a note
    drive(1, 4'b1000, 3'd2, 0);
    tick();
    drive(0, 4'd0, 3'd0, 0);
    repeat (50) tick();
    chk("pre_rst_conta", int'(buzzer_conta), 1);
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    compare_all();
    chk("async_rst_conta", int'(buzzer_conta), 0);
    chk("async_rst_pronto", int'(pronto), 1);
    tick();
    reset = 1'b0;
    drive(1, 4'b0001, 3'd1, 0);
    tick();
    drive(0, 4'd0, 3'd0, 0);
    len  = 0;
    fims = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (buzzer_conta) len++;
      if (fim_nota) fims++;
    end
    chk("post_rst_len", len, UNIT_MS);
    chk("post_rst_fim", fims, 1);

    // randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      logic [3:0] n;
      logic [2:0] d;
      if ($urandom_range(0, 4) != 0) n = 4'b0001 << $urandom_range(0, 3);
      else n = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) d = 3'($urandom_range(0, 7));
      else d = 3'($urandom_range(1, 2));
      drive($urandom_range(0, 7) == 0, n, d, $urandom_range(0, 199) == 0);
      reset = ($urandom_range(0, 1499) == 0);
      tick();
    end
    reset = 1'b0;
    drive(0, 4'd0, 3'd0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/buzzer_sequencer.md
BUZZER_SEQUENCER -- requirements
Module: buzzer_sequencer

Interface
REQ-001 Parameter: DEPTH, 4, request-queue depth in entries, power of two.
REQ-002 Parameter: UNIT_MS, 100, clock cycles per duration unit.
REQ-003 Parameter: GAP_MS, 50, silent cycles between notes (used only with gap feature).
REQ-004 Port: clock  in  1  1 kHz system clock, all logic on its rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: req  in  1  enqueue request, sampled each rising edge.
REQ-007 Port: nota  in  4  one-hot tone: 0001=125Hz, 0010=250Hz, 0100=333Hz, 1000=500Hz.
REQ-008 Port: duracao  in  3  note length in UNIT_MS units, 1..7.
REQ-009 Port: cancelar  in  1  flush queue and abort current note.
REQ-010 Port: pronto  out  1  queue not full.
REQ-011 Port: nivel  out  3  queue occupancy, 0..DEPTH.
REQ-012 Port: tocando  out  1  high in any state other than IDLE.
REQ-013 Port: buzzer_conta  out  1  drives the buzzer conta input.
REQ-014 Port: buzzer_seletor  out  4  drives the buzzer one-hot seletor input.
REQ-015 Port: fim_nota  out  1  one-cycle pulse per completed note.
REQ-016 Port: erro  out  1  one-cycle pulse per rejected request.

Function
REQ-017 Request accepted on an edge with req=1, pronto=1, cancelar=0, nota one-hot and duracao!=0; {nota,duracao} pushed to the queue.
REQ-018 Request with req=1 and invalid nota (not exactly one bit set) or duracao=0 is not enqueued; erro pulses on the following cycle.
REQ-019 Request with req=1 while the queue is full is dropped silently, even if a pop occurs on the same edge; erro stays low.
REQ-020 FSM states: IDLE, LOAD, PLAY, GAP.
REQ-021 IDLE -> LOAD when the queue is non-empty; LOAD pops the head and registers nota and duracao*UNIT_MS into a 10-bit down-counter; LOAD -> PLAY.
REQ-022 PLAY lasts exactly duracao*UNIT_MS cycles, with buzzer_conta=1 and buzzer_seletor=registered nota.
REQ-023 In IDLE, LOAD and GAP: buzzer_conta=0 and buzzer_seletor=0000.
REQ-024 Latency: request accepted on edge N into an empty queue while in IDLE -> buzzer_conta rises after edge N+2.
REQ-025 fim_nota pulses in the first cycle after the last PLAY cycle.
REQ-026 After PLAY, the FSM goes to LOAD if the queue is non-empty, otherwise to IDLE (gap feature excluded).
REQ-027 Notes play in FIFO order; simultaneous push and pop on a non-full queue leaves nivel unchanged.
REQ-028 cancelar=1 on an edge: queue emptied, FSM -> IDLE, buzzer outputs zero next cycle, no fim_nota, any same-edge req dropped.

Reset
REQ-029 reset=1 immediately forces state IDLE, empty queue, counter 0, and all outputs 0 except pronto=1, independent of clock.
REQ-030 Reset asserted mid-note aborts the note with no fim_nota; operation resumes from IDLE on the first edge after release.

Configuration
REQ-031 Macro BUZZER_SEQ_GAP_EN defined: PLAY -> GAP for exactly GAP_MS silent cycles, then LOAD if queue non-empty, otherwise IDLE; cancelar in GAP -> IDLE.
REQ-032 Macro BUZZER_SEQ_GAP_EN undefined: GAP state and GAP_MS logic absent; behaviour per REQ-026.

Structure
REQ-033 Shared package holds tone one-hot codes, FSM state encodings and the UNIT_MS default.
REQ-034 Queue is a separate sub-module fila_notas (7-bit wide, DEPTH deep, push/pop/flush, full/empty/count).

Verification
REQ-035 Reset, then req with nota=0010, duracao=1 -> conta high for exactly 100 cycles starting edge N+2, seletor=0010, then one fim_nota pulse, then IDLE.
REQ-036 Enqueue 4 notes 0001/0010/0100/1000 with duracao 1 -> pronto=0 at nivel=4; a 5th req is dropped; the 4 notes play in order with fim_nota x4.
REQ-037 req with nota=0011 and with duracao=0 -> erro pulse each time, nivel unchanged.
REQ-038 Assert cancelar 30 cycles into a 3-unit note with 2 notes queued -> outputs 0 next cycle, nivel=0, no fim_nota.
REQ-039 Two queued notes with BUZZER_SEQ_GAP_EN defined -> 50 silent cycles between them; undefined -> exactly 1 silent cycle (LOAD).
REQ-040 Assert reset asynchronously mid-PLAY -> outputs 0 before the next edge; a new request after release plays normally.
